// File: rtl/riscv_core_mul_pkg.sv
// Shared types for the RV64M multiply sequencer and its Booth datapath.
package riscv_core_mul_pkg;

  localparam int unsigned MUL_CYCLES_MAX = 15;
  localparam int unsigned MUL_CNT_W      = 4;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_ctrl_state_e;

  // Operation descriptor latched alongside the operands
  typedef struct packed {
    mul_op_e op;
    logic    isword;
  } mul_ctrl_t;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic mul_a_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH
  function automatic logic mul_b_signed(input mul_op_e op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/riscv_core_mul.sv
// Combinational radix-16 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Operands are extended by one bit so signed and unsigned forms share one signed array.
module riscv_core_mul
  import riscv_core_mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_mul_en,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  input  mul_op_e         i_mul_control,
  input  logic            i_mul_isword,
  output logic [XLEN-1:0] o_mul_result
);

  localparam int unsigned EW = XLEN + 1;          // extended operand width
  localparam int unsigned ND = (EW + 3) / 4;      // number of radix-16 digits
  localparam int unsigned BW = 4 * ND + 1;        // recoded multiplier incl. implicit b[-1]
  localparam int unsigned PW = 2 * XLEN;          // product width (modulo arithmetic)

  logic [XLEN-1:0] w_a_iso;
  logic [XLEN-1:0] w_b_iso;
  logic [EW-1:0]   w_a_ext;
  logic [EW-1:0]   w_b_ext;
  logic [BW-1:0]   w_b_booth;
  logic [PW-1:0]   w_m1, w_m2, w_m3, w_m4, w_m5, w_m6, w_m7, w_m8;
  logic [PW-1:0]   w_acc;
  logic [PW-1:0]   w_pp;
  logic [4:0]      w_grp;
  logic [3:0]      w_u;
  logic [3:0]      w_mag;

  // Operand isolation keeps the array quiet outside the BUSY window
  assign w_a_iso = i_mul_en ? i_mul_srcA : '0;
  assign w_b_iso = i_mul_en ? i_mul_srcB : '0;

  // Sign or zero extension selected by the operation
  assign w_a_ext   = {mul_a_signed(i_mul_control) & w_a_iso[XLEN-1], w_a_iso};
  assign w_b_ext   = {mul_b_signed(i_mul_control) & w_b_iso[XLEN-1], w_b_iso};
  assign w_b_booth = {(BW-1)'($signed(w_b_ext)), 1'b0};

  // Precomputed multiples 1..8 of the multiplicand
  assign w_m1 = PW'($signed(w_a_ext));
  assign w_m2 = w_m1 << 1;
  assign w_m3 = w_m2 + w_m1;
  assign w_m4 = w_m1 << 2;
  assign w_m5 = w_m4 + w_m1;
  assign w_m6 = w_m3 << 1;
  assign w_m8 = w_m1 << 3;
  assign w_m7 = w_m8 - w_m1;

  // Booth recoding and partial-product summation
  always_comb begin
    w_acc = '0;
    w_pp  = '0;
    w_grp = '0;
    w_u   = '0;
    w_mag = '0;
    for (int i = 0; i < ND; i++) begin
      w_grp = w_b_booth[4*i +: 5];
      w_u   = {1'b0, w_grp[3:1]} + {3'b000, w_grp[0]};
      w_mag = w_grp[4] ? (4'd8 - w_u) : w_u;
      case (w_mag)
        4'd1:    w_pp = w_m1;
        4'd2:    w_pp = w_m2;
        4'd3:    w_pp = w_m3;
        4'd4:    w_pp = w_m4;
        4'd5:    w_pp = w_m5;
        4'd6:    w_pp = w_m6;
        4'd7:    w_pp = w_m7;
        4'd8:    w_pp = w_m8;
        default: w_pp = '0;
      endcase
      if (w_grp[4]) begin
        w_pp = -w_pp;
      end
      w_acc = w_acc + (w_pp << (4 * i));
    end
  end

  // Result selection: W-form sign-extends the low word, otherwise low or high half
  always_comb begin
    if (i_mul_isword) begin
      o_mul_result = {{(XLEN-32){w_acc[31]}}, w_acc[31:0]};
    end else if (i_mul_control == MUL_OP_MUL) begin
      o_mul_result = w_acc[XLEN-1:0];
    end else begin
      o_mul_result = w_acc[PW-1:XLEN];
    end
  end

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// Multi-cycle sequencer for the Booth multiplier in EX.
// Operands are held stable for MUL_CYCLES cycles (legal 1..15) so the
// array can be timed as a multicycle path; result is held until acked.
module riscv_core_mul_ctrl
  import riscv_core_mul_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             i_mul_clk,
  input  logic             i_mul_rst_n,
  input  logic             i_mulctrl_valid,
  output logic             o_mulctrl_ready,
  input  logic [XLEN-1:0]  i_mulctrl_srcA,
  input  logic [XLEN-1:0]  i_mulctrl_srcB,
  input  logic [1:0]       i_mulctrl_control,
  input  logic             i_mulctrl_isword,
  input  logic             i_mulctrl_flush,
  output logic             o_mulctrl_done,
  input  logic             i_mulctrl_ack,
  output logic [XLEN-1:0]  o_mulctrl_result,
  output logic [CNT_W-1:0] o_mulctrl_ops_cnt
);

  localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(MUL_CYCLES - 1);

  mul_ctrl_state_e      r_state;
  logic [XLEN-1:0]      r_srcA;
  logic [XLEN-1:0]      r_srcB;
  mul_ctrl_t            r_ctrl;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]      r_result;
  logic                 r_done;
  logic                 r_en;
  logic [CNT_W-1:0]     r_ops_cnt;

  logic                 w_ready;
  logic                 w_accept;
  logic [XLEN-1:0]      w_product;

  // Accept when idle, or when the pending result is consumed this cycle
  assign w_ready  = !i_mulctrl_flush &
                    ((r_state == IDLE) | ((r_state == DONE) & i_mulctrl_ack));
  assign w_accept = i_mulctrl_valid & w_ready;

  // Operand/control registers change only on accept
  always_ff @(posedge i_mul_clk) begin
    if (!i_mul_rst_n) begin
      r_srcA <= '0;
      r_srcB <= '0;
      r_ctrl <= '0;
    end else if (w_accept) begin
      r_srcA <= i_mulctrl_srcA;
      r_srcB <= i_mulctrl_srcB;
      r_ctrl <= '{op: mul_op_e'(i_mulctrl_control), isword: i_mulctrl_isword};
    end
  end

  // Sequencer: IDLE -> BUSY (MUL_CYCLES) -> DONE, with flush and op counting
  always_ff @(posedge i_mul_clk) begin
    if (!i_mul_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_en      <= 1'b0;
      r_ops_cnt <= '0;
    end else if (i_mulctrl_flush) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_en    <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_result <= w_product;
            r_done   <= 1'b1;
            r_en     <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (i_mulctrl_ack) begin
            r_ops_cnt <= r_ops_cnt + 1'b1;
            r_done    <= 1'b0;
            if (w_accept) begin
              r_cnt   <= CNT_INIT;
              r_en    <= 1'b1;
              r_state <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  // Datapath fed straight from the held operand registers
  riscv_core_mul #(
    .XLEN(XLEN)
  ) u_riscv_core_mul (
    .i_mul_en      (r_en),
    .i_mul_srcA    (r_srcA),
    .i_mul_srcB    (r_srcB),
    .i_mul_control (r_ctrl.op),
    .i_mul_isword  (r_ctrl.isword),
    .o_mul_result  (w_product)
  );

  assign o_mulctrl_ready   = w_ready;
  assign o_mulctrl_done    = r_done;
  assign o_mulctrl_result  = r_result;
  assign o_mulctrl_ops_cnt = r_ops_cnt;

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Directed + scoreboard bench for riscv_core_mul_ctrl (MUL_CYCLES=2 main, 1 and 15 latency sweep).
module tb_riscv_core_mul_ctrl;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned MC    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, valid, flush, ack, isword;
  logic [XLEN-1:0]  srcA, srcB;
  logic [1:0]       control;

  logic             ready, done, ready1, done1, ready15, done15;
  logic [XLEN-1:0]  result, result1, result15;
  logic [CNT_W-1:0] ops, ops1, ops15;

  riscv_core_mul_ctrl #(.XLEN(XLEN), .MUL_CYCLES(MC), .CNT_W(CNT_W)) dut (
    .i_mul_clk(clk), .i_mul_rst_n(rst_n), .i_mulctrl_valid(valid), .o_mulctrl_ready(ready),
    .i_mulctrl_srcA(srcA), .i_mulctrl_srcB(srcB), .i_mulctrl_control(control),
    .i_mulctrl_isword(isword), .i_mulctrl_flush(flush), .o_mulctrl_done(done),
    .i_mulctrl_ack(ack), .o_mulctrl_result(result), .o_mulctrl_ops_cnt(ops));

  riscv_core_mul_ctrl #(.XLEN(XLEN), .MUL_CYCLES(1), .CNT_W(CNT_W)) dut1 (
    .i_mul_clk(clk), .i_mul_rst_n(rst_n), .i_mulctrl_valid(valid), .o_mulctrl_ready(ready1),
    .i_mulctrl_srcA(srcA), .i_mulctrl_srcB(srcB), .i_mulctrl_control(control),
    .i_mulctrl_isword(isword), .i_mulctrl_flush(flush), .o_mulctrl_done(done1),
    .i_mulctrl_ack(ack), .o_mulctrl_result(result1), .o_mulctrl_ops_cnt(ops1));

  riscv_core_mul_ctrl #(.XLEN(XLEN), .MUL_CYCLES(15), .CNT_W(CNT_W)) dut15 (
    .i_mul_clk(clk), .i_mul_rst_n(rst_n), .i_mulctrl_valid(valid), .o_mulctrl_ready(ready15),
    .i_mulctrl_srcA(srcA), .i_mulctrl_srcB(srcB), .i_mulctrl_control(control),
    .i_mulctrl_isword(isword), .i_mulctrl_flush(flush), .o_mulctrl_done(done15),
    .i_mulctrl_ack(ack), .o_mulctrl_result(result15), .o_mulctrl_ops_cnt(ops15));

  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0]  sb[$];
  logic [CNT_W-1:0] exp_ops = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference via wide signed multiply of sign/zero-extended operands
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] c, input logic w);
    logic signed [129:0] sa, sbv, p;
    sa  = (c == 2'b01 || c == 2'b10) ? {{66{a[63]}}, a} : {66'b0, a};
    sbv = (c == 2'b01) ? {{66{b[63]}}, b} : {66'b0, b};
    p   = sa * sbv;
    if (w)               return {{32{p[31]}}, p[31:0]};
    else if (c == 2'b00) return p[63:0];
    else                 return p[127:64];
  endfunction

  // Present one request; starts and ends just after a rising edge
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c, input logic w);
    srcA = a; srcB = b; control = c; isword = w; valid = 1'b1;
    @(negedge clk);
    chk("req_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Count cycles after accept until done; ends on a falling edge
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic take(input string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, result);
    end else begin
      e = sb.pop_front();
      chk(tag, result, e);
    end
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] c, input logic w, input logic [63:0] exp);
    int lat;
    sb.push_back(exp);
    send(a, b, c, w);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(MC + 1));
    take(tag);
    @(posedge clk); #1;
    exp_ops++;
    chk({tag, "_ops"}, 64'(ops), 64'(exp_ops));
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, l1, l2, l15;
    logic [63:0] held, ra, rb;
    logic [1:0]  rc;
    logic        rw, stable;

    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ack = 1'b1;
    srcA = '0; srcB = '0; control = '0; isword = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_result", result,      64'd0);
    chk("rst_ops",    64'(ops),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",  64'(ready),  64'd1);
    @(posedge clk); #1;

    // Directed functional cases
    do_op("mul_3x5",   64'd3, 64'd5, 2'b00, 1'b0, 64'd15);
    do_op("mulhu_ones", '1, '1, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("mulh_m1",    '1, '1, 2'b01, 1'b0, 64'd0);
    do_op("mulhsu_m1",  '1, '1, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("mulw",  64'h0000_0000_4000_0000, 64'd2, 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000);
    do_op("mul64", 64'h0000_0000_4000_0000, 64'd2, 2'b00, 1'b0, 64'h0000_0000_8000_0000);

    // Random operands checked against the wide-multiply reference
    for (int k = 0; k < 8; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 2'($urandom_range(0, 3));
      rw = (rc == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_op("rand", ra, rb, rc, rw, ref_mul(ra, rb, rc, rw));
    end

    // Backpressure: result held with ack low, then back-to-back accept on ack
    ack = 1'b0;
    sb.push_back(64'd42);
    send(64'd6, 64'd7, 2'b00, 1'b0);
    wait_done(lat);
    chk("bp_lat", 64'(lat), 64'(MC + 1));
    held = result;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!done || result !== held || ready) stable = 1'b0;
    end
    chk("bp_done",   64'(done),   64'd1);
    chk("bp_ready",  64'(ready),  64'd0);
    chk("bp_stable", 64'(stable), 64'd1);
    take("bp_result");
    ack = 1'b1; valid = 1'b1;
    srcA = 64'hFFFF_FFFF_FFFF_FFFD; srcB = 64'd5; control = 2'b00; isword = 1'b0;
    #1;
    chk("b2b_ready", 64'(ready), 64'd1);
    sb.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    @(posedge clk); #1;
    valid = 1'b0;
    exp_ops++;
    chk("b2b_done_low", 64'(done), 64'd0);
    chk("b2b_ops",      64'(ops),  64'(exp_ops));
    wait_done(lat);
    chk("b2b_lat", 64'(lat), 64'(MC + 1));
    take("b2b_result");
    @(posedge clk); #1;
    exp_ops++;
    chk("b2b_ops2", 64'(ops), 64'(exp_ops));

    // Flush during first BUSY cycle
    send(64'd9, 64'd9, 2'b00, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flush_busy_nodone", 64'(seen),  64'd0);
    chk("flush_busy_ops",    64'(ops),   64'(exp_ops));
    chk("flush_busy_ready",  64'(ready), 64'd1);
    @(posedge clk); #1;

    // Flush together with valid in IDLE: not accepted
    srcA = 64'd11; srcB = 64'd11; control = 2'b00; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flushv_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flushv_nodone", 64'(seen),  64'd0);
    chk("flushv_idle",   64'(ready), 64'd1);
    @(posedge clk); #1;

    // Flush together with ack in DONE: flush wins, no count, result kept
    ack = 1'b0;
    send(64'd12, 64'd12, 2'b00, 1'b0);
    wait_done(lat);
    ack = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushack_done",   64'(done), 64'd0);
    chk("flushack_ops",    64'(ops),  64'(exp_ops));
    chk("flushack_result", result,    64'd144);

    // Reset while DONE
    ack = 1'b0;
    send(64'd13, 64'd13, 2'b00, 1'b0);
    wait_done(lat);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ops = '0;
    chk("rstdone_done",   64'(done), 64'd0);
    chk("rstdone_result", result,    64'd0);
    chk("rstdone_ops",    64'(ops),  64'd0);
    @(negedge clk);
    chk("rstdone_ready", 64'(ready), 64'd1);
    ack = 1'b1;
    @(posedge clk); #1;

    // Latency sweep across MUL_CYCLES = 1, 2, 15
    sb.push_back(64'd63);
    send(64'd7, 64'd9, 2'b00, 1'b0);
    l1 = 0; l2 = 0; l15 = 0; lat = 0;
    while ((l1 == 0 || l2 == 0 || l15 == 0) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done1 && l1 == 0) begin
        l1 = lat;
        chk("sw1_result", result1, 64'd63);
      end
      if (done && l2 == 0) begin
        l2 = lat;
        take("sw2_result");
      end
      if (done15 && l15 == 0) begin
        l15 = lat;
        chk("sw15_result", result15, 64'd63);
      end
    end
    chk("sw1_lat",  64'(l1),  64'd2);
    chk("sw2_lat",  64'(l2),  64'd3);
    chk("sw15_lat", 64'(l15), 64'd16);
    @(posedge clk); #1;
    exp_ops++;
    chk("sw2_ops",  64'(ops),   64'(exp_ops));
    chk("sw15_ops", 64'(ops15), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
